// File: rtl/is_uart_rx_ctrl_if.sv
// Byte-stream interface of the UART receive controller: serial line in, received
// byte out on valid/ready, plus status pulses. Member names follow the controller's view.
interface is_uart_rx_ctrl_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rxd_i;
  logic                 ready_i;
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 frame_err_o;
  logic                 overrun_o;
  logic                 busy_o;

  modport master (
    input  rxd_i,
    input  ready_i,
    output data_o,
    output valid_o,
    output frame_err_o,
    output overrun_o,
    output busy_o
  );

  modport slave (
    output rxd_i,
    output ready_i,
    input  data_o,
    input  valid_o,
    input  frame_err_o,
    input  overrun_o,
    input  busy_o
  );
endinterface

// File: rtl/is_uart_rx_ctrl.sv
// UART receive controller: start/data/stop bit timing on a synchronized RX line,
// delivering bytes on valid/ready with framing-error and overrun pulses.
module is_uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  is_uart_rx_ctrl_if.master bus_io
);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  busy_q, busy_d;
  logic                  deliver;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~bus_io.ready_i;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!bus_io.rxd_i) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == HalfLast) begin
          // A start bit that is gone by mid-bit is treated as line noise.
          if (!bus_io.rxd_i) begin
            state_d = StData;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == BitLast) begin
          shift_d = {bus_io.rxd_i, shift_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StStop: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (bus_io.rxd_i) begin
            state_d = StIdle;
            deliver = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // Hold off until the line recovers so a break yields a single error.
        if (bus_io.rxd_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (deliver) begin
      if (!valid_q || bus_io.ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus_io.data_o      = data_q;
  assign bus_io.valid_o     = valid_q;
  assign bus_io.frame_err_o = ferr_q;
  assign bus_io.overrun_o   = ovr_q;
  assign bus_io.busy_o      = busy_q;
endmodule

// File: tb/tb_is_uart_rx_ctrl.sv
// Bench for is_uart_rx_ctrl: directed frame scenarios plus random back-to-back frames
// checked against a frame-level model of the delivered byte and status pulses.
module tb_is_uart_rx_ctrl;
  localparam int Cpb      = 16;
  localparam int Db       = 8;
  localparam int StopIdx  = Cpb / 2 + (Db + 1) * Cpb;
  localparam int FrameLen = (Db + 2) * Cpb;

  logic clk_i = 1'b0;
  logic rst_i;

  is_uart_rx_ctrl_if #(.DATA_BITS(Db)) bus ();

  is_uart_rx_ctrl #(
    .CLKS_PER_BIT (Cpb),
    .DATA_BITS    (Db)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus_io (bus)
  );

  always #5 clk_i = ~clk_i;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Per-edge capture of one frame, index i = sample just after edge E+i.
  logic          r_valid[FrameLen];
  logic [Db-1:0] r_data[FrameLen];
  logic          r_ferr[FrameLen];
  logic          r_ovr[FrameLen];
  logic          r_busy[FrameLen];

  logic          m_valid;
  logic [Db-1:0] m_data;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [Db-1:0] d, input logic stop_bit, input logic rdy_flip);
    logic          rdy_save;
    logic [Db+1:0] bits;
    bits      = {stop_bit, d, 1'b0};
    rdy_save  = bus.ready_i;
    bus.rxd_i = bits[0];
    for (int i = 0; i < FrameLen; i++) begin
      tick();
      r_valid[i] = bus.valid_o;
      r_data[i]  = bus.data_o;
      r_ferr[i]  = bus.frame_err_o;
      r_ovr[i]   = bus.overrun_o;
      r_busy[i]  = bus.busy_o;
      if (i + 1 < FrameLen) bus.rxd_i = bits[(i + 1) / Cpb];
      if (rdy_flip && i + 1 == StopIdx) bus.ready_i = ~rdy_save;
      if (rdy_flip && i == StopIdx) bus.ready_i = rdy_save;
    end
  endtask

  task automatic test_reset();
    rst_i       = 1'b0;
    bus.rxd_i   = 1'b1;
    bus.ready_i = 1'b0;
    #1;
    chk_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.valid_o); else pass_cnt++;
    chk_cnt++; if (bus.data_o !== 8'h00) $display("FAIL rst_data: got %h want 00", bus.data_o); else pass_cnt++;
    chk_cnt++; if (bus.frame_err_o !== 1'b0) $display("FAIL rst_ferr: got %b want 0", bus.frame_err_o); else pass_cnt++;
    chk_cnt++; if (bus.overrun_o !== 1'b0) $display("FAIL rst_ovr: got %b want 0", bus.overrun_o); else pass_cnt++;
    chk_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy_o); else pass_cnt++;
    tick();
    tick();
    #2 rst_i = 1'b1;
    tick();
    tick();
    chk_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL rst_idle_busy: got %b want 0", bus.busy_o); else pass_cnt++;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  task automatic test_frame_a5();
    bus.ready_i = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    chk_cnt++; if (r_busy[0] !== 1'b1) $display("FAIL a5_busy_rise: got %b want 1", r_busy[0]); else pass_cnt++;
    chk_cnt++; if (r_valid[StopIdx-1] !== 1'b0) $display("FAIL a5_valid_early: got %b want 0", r_valid[StopIdx-1]); else pass_cnt++;
    chk_cnt++; if (r_valid[StopIdx] !== 1'b1) $display("FAIL a5_valid: got %b want 1", r_valid[StopIdx]); else pass_cnt++;
    chk_cnt++; if (r_data[StopIdx] !== 8'hA5) $display("FAIL a5_data: got %h want a5", r_data[StopIdx]); else pass_cnt++;
    chk_cnt++; if (r_busy[StopIdx-1] !== 1'b1) $display("FAIL a5_busy_hold: got %b want 1", r_busy[StopIdx-1]); else pass_cnt++;
    chk_cnt++; if (r_busy[StopIdx] !== 1'b0) $display("FAIL a5_busy_fall: got %b want 0", r_busy[StopIdx]); else pass_cnt++;
    chk_cnt++; if (r_valid[StopIdx+1] !== 1'b0) $display("FAIL a5_valid_one_cycle: got %b want 0", r_valid[StopIdx+1]); else pass_cnt++;
    m_valid = 1'b0;
    m_data  = 8'hA5;
  endtask

  task automatic test_glitch();
    logic [19:0] busy_v;
    logic [19:0] act_v;
    bus.rxd_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      busy_v[i] = bus.busy_o;
      act_v[i]  = bus.valid_o | bus.frame_err_o | bus.overrun_o;
      if (i == 3) bus.rxd_i = 1'b1;
    end
    chk_cnt++; if (busy_v !== 20'h000FF) $display("FAIL glitch_busy: got %h want 000ff", busy_v); else pass_cnt++;
    chk_cnt++; if (act_v !== 20'h0) $display("FAIL glitch_outputs: got %h want 00000", act_v); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int   ferr_n;
    logic any_valid;
    logic all_busy;
    bus.ready_i = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    ferr_n    = 0;
    any_valid = 1'b0;
    all_busy  = 1'b1;
    for (int i = 0; i < FrameLen; i++) begin
      ferr_n    += int'(r_ferr[i]) + int'(r_ovr[i]);
      any_valid |= r_valid[i];
      all_busy  &= r_busy[i];
    end
    chk_cnt++; if (r_ferr[StopIdx] !== 1'b1) $display("FAIL ferr_pulse: got %b want 1", r_ferr[StopIdx]); else pass_cnt++;
    chk_cnt++; if (ferr_n != 1) $display("FAIL ferr_pulse_count: got %0d want 1", ferr_n); else pass_cnt++;
    chk_cnt++; if (any_valid !== 1'b0) $display("FAIL ferr_no_valid: got %b want 0", any_valid); else pass_cnt++;
    chk_cnt++; if (all_busy !== 1'b1) $display("FAIL ferr_busy_frame: got %b want 1", all_busy); else pass_cnt++;
    ferr_n   = 0;
    all_busy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      all_busy &= bus.busy_o;
      ferr_n   += int'(bus.frame_err_o) + int'(bus.valid_o);
    end
    chk_cnt++; if (all_busy !== 1'b1) $display("FAIL break_busy: got %b want 1", all_busy); else pass_cnt++;
    chk_cnt++; if (ferr_n != 0) $display("FAIL break_repeat: got %0d want 0", ferr_n); else pass_cnt++;
    bus.rxd_i = 1'b1;
    tick();
    chk_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL break_release_busy: got %b want 0", bus.busy_o); else pass_cnt++;
    bus.ready_i = 1'b1;
    send_frame(8'h01, 1'b1, 1'b0);
    chk_cnt++; if (r_valid[StopIdx] !== 1'b1) $display("FAIL after_err_valid: got %b want 1", r_valid[StopIdx]); else pass_cnt++;
    chk_cnt++; if (r_data[StopIdx] !== 8'h01) $display("FAIL after_err_data: got %h want 01", r_data[StopIdx]); else pass_cnt++;
    m_valid = 1'b0;
    m_data  = 8'h01;
  endtask

  task automatic test_overrun();
    int   pulse_n;
    logic all_valid;
    bus.ready_i = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    chk_cnt++; if (r_data[StopIdx] !== 8'h11) $display("FAIL ovr_first_data: got %h want 11", r_data[StopIdx]); else pass_cnt++;
    send_frame(8'h22, 1'b1, 1'b0);
    pulse_n   = 0;
    all_valid = 1'b1;
    for (int i = 0; i < FrameLen; i++) begin
      pulse_n   += int'(r_ovr[i]) + int'(r_ferr[i]);
      all_valid &= r_valid[i];
    end
    chk_cnt++; if (all_valid !== 1'b1) $display("FAIL ovr_valid_held: got %b want 1", all_valid); else pass_cnt++;
    chk_cnt++; if (r_data[FrameLen-1] !== 8'h11) $display("FAIL ovr_data_kept: got %h want 11", r_data[FrameLen-1]); else pass_cnt++;
    chk_cnt++; if (r_ovr[StopIdx] !== 1'b1) $display("FAIL ovr_pulse: got %b want 1", r_ovr[StopIdx]); else pass_cnt++;
    chk_cnt++; if (pulse_n != 1) $display("FAIL ovr_pulse_count: got %0d want 1", pulse_n); else pass_cnt++;
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    chk_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL ovr_accept: got %b want 0", bus.valid_o); else pass_cnt++;
    m_valid = 1'b0;
    m_data  = 8'h11;
  endtask

  task automatic test_ready_at_stop();
    int ovr_n;
    bus.ready_i = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    ovr_n = 0;
    for (int i = 0; i < FrameLen; i++) ovr_n += int'(r_ovr[i]);
    chk_cnt++; if (r_data[StopIdx-1] !== 8'h11) $display("FAIL ras_old_data: got %h want 11", r_data[StopIdx-1]); else pass_cnt++;
    chk_cnt++; if (r_valid[StopIdx] !== 1'b1) $display("FAIL ras_valid: got %b want 1", r_valid[StopIdx]); else pass_cnt++;
    chk_cnt++; if (r_data[StopIdx] !== 8'h22) $display("FAIL ras_data: got %h want 22", r_data[StopIdx]); else pass_cnt++;
    chk_cnt++; if (ovr_n != 0) $display("FAIL ras_no_overrun: got %0d want 0", ovr_n); else pass_cnt++;
    chk_cnt++; if (r_valid[FrameLen-1] !== 1'b1) $display("FAIL ras_valid_held: got %b want 1", r_valid[FrameLen-1]); else pass_cnt++;
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    m_valid = 1'b0;
    m_data  = 8'h22;
  endtask

  task automatic test_mid_reset();
    logic [Db+1:0] bits;
    bus.ready_i = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0);
    bits      = {1'b1, 8'h96, 1'b0};
    bus.rxd_i = bits[0];
    // Stop inside data bit 3 (window E+64..E+79).
    for (int i = 0; i < 72; i++) begin
      tick();
      bus.rxd_i = bits[(i + 1) / Cpb];
    end
    chk_cnt++; if ({bus.busy_o, bus.valid_o} !== 2'b11) $display("FAIL mrst_pre: got %b want 11", {bus.busy_o, bus.valid_o}); else pass_cnt++;
    #2 rst_i = 1'b0;
    #1;
    chk_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL mrst_valid: got %b want 0", bus.valid_o); else pass_cnt++;
    chk_cnt++; if (bus.data_o !== 8'h00) $display("FAIL mrst_data: got %h want 00", bus.data_o); else pass_cnt++;
    chk_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL mrst_busy: got %b want 0", bus.busy_o); else pass_cnt++;
    chk_cnt++; if ({bus.frame_err_o, bus.overrun_o} !== 2'b00) $display("FAIL mrst_pulses: got %b want 00", {bus.frame_err_o, bus.overrun_o}); else pass_cnt++;
    bus.rxd_i = 1'b1;
    tick();
    tick();
    #2 rst_i = 1'b1;
    tick();
    chk_cnt++; if ({bus.valid_o, bus.frame_err_o, bus.overrun_o} !== 3'b000) $display("FAIL mrst_after: got %b want 000", {bus.valid_o, bus.frame_err_o, bus.overrun_o}); else pass_cnt++;
    bus.ready_i = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0);
    chk_cnt++; if (r_valid[StopIdx] !== 1'b1) $display("FAIL mrst_5a_valid: got %b want 1", r_valid[StopIdx]); else pass_cnt++;
    chk_cnt++; if (r_data[StopIdx] !== 8'h5A) $display("FAIL mrst_5a_data: got %h want 5a", r_data[StopIdx]); else pass_cnt++;
    chk_cnt++; if (r_ferr[StopIdx] !== 1'b0) $display("FAIL mrst_5a_ferr: got %b want 0", r_ferr[StopIdx]); else pass_cnt++;
    m_valid = 1'b0;
    m_data  = 8'h5A;
  endtask

  // Random back-to-back frames; the model tracks only the held byte and its valid flag.
  task automatic test_back_to_back();
    logic          r, s, pre, exp_v, exp_ovr, exp_ferr;
    logic [Db-1:0] d, exp_d;
    int            pulse_n;
    for (int n = 0; n < 12; n++) begin
      r           = 1'($urandom_range(0, 1));
      s           = ($urandom_range(0, 3) != 0);
      d           = Db'($urandom);
      bus.ready_i = r;
      pre         = m_valid && !r;
      exp_ovr     = 1'b0;
      exp_ferr    = 1'b0;
      m_valid     = pre;
      if (s) begin
        if (!pre) begin
          m_valid = 1'b1;
          m_data  = d;
        end else begin
          exp_ovr = 1'b1;
        end
      end else begin
        exp_ferr = 1'b1;
      end
      exp_v = m_valid;
      exp_d = m_data;
      send_frame(d, s, 1'b0);
      m_valid = m_valid && !r;
      pulse_n = 0;
      for (int i = 0; i < FrameLen; i++) pulse_n += int'(r_ovr[i]) + int'(r_ferr[i]);
      chk_cnt++; if (r_valid[StopIdx-1] !== pre) $display("FAIL b2b%0d_valid_pre: got %b want %b", n, r_valid[StopIdx-1], pre); else pass_cnt++;
      chk_cnt++; if (r_valid[StopIdx] !== exp_v) $display("FAIL b2b%0d_valid: got %b want %b", n, r_valid[StopIdx], exp_v); else pass_cnt++;
      if (exp_v) begin
        chk_cnt++; if (r_data[StopIdx] !== exp_d) $display("FAIL b2b%0d_data: got %h want %h", n, r_data[StopIdx], exp_d); else pass_cnt++;
      end
      chk_cnt++; if (r_ovr[StopIdx] !== exp_ovr) $display("FAIL b2b%0d_ovr: got %b want %b", n, r_ovr[StopIdx], exp_ovr); else pass_cnt++;
      chk_cnt++; if (r_ferr[StopIdx] !== exp_ferr) $display("FAIL b2b%0d_ferr: got %b want %b", n, r_ferr[StopIdx], exp_ferr); else pass_cnt++;
      chk_cnt++; if (pulse_n != int'(exp_ovr) + int'(exp_ferr)) $display("FAIL b2b%0d_pulses: got %0d want %0d", n, pulse_n, int'(exp_ovr) + int'(exp_ferr)); else pass_cnt++;
      chk_cnt++; if (r_busy[StopIdx] !== !s) $display("FAIL b2b%0d_busy: got %b want %b", n, r_busy[StopIdx], !s); else pass_cnt++;
      chk_cnt++; if (r_valid[FrameLen-1] !== m_valid) $display("FAIL b2b%0d_valid_post: got %b want %b", n, r_valid[FrameLen-1], m_valid); else pass_cnt++;
      if (!s) begin
        bus.rxd_i = 1'b1;
        tick();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_ready_at_stop();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/is_uart_rx_ctrl.md
# is_uart_rx_ctrl

UART receive controller that sequences the synchronized serial line into bytes. It sits directly after the 3-flop RX synchronizer: it takes the already-synchronized `rxd` level, runs the start/data/stop bit-timing state machine, and presents each received byte on a valid/ready interface. It also reports framing errors and overruns.

## Interface
- CLKS_PER_BIT, default 868: clk_i cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- DATA_BITS, default 8: data bits per frame, 5..8.

- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-low
- rxd_i  in  1  synchronized RX line; idle = 1
- ready_i  in  1  consumer accepts data_o this cycle
- data_o  out  DATA_BITS  received byte; stable while valid_o = 1
- valid_o  out  1  data_o holds an unaccepted byte
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overrun_o  out  1  one-cycle pulse: frame completed while previous byte unaccepted
- busy_o  out  1  1 whenever state ≠ IDLE

## Operation
- HALF = CLKS_PER_BIT/2 (integer division). Baud counter `cnt` is $clog2(CLKS_PER_BIT) wide. Bit index counter is $clog2(DATA_BITS) wide.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rxd_i = 0 → START, cnt ← 0.
- START: cnt increments each cycle. When cnt = HALF-1:
  - rxd_i = 0 → DATA, cnt ← 0, bit index ← 0.
  - rxd_i = 1 → IDLE (glitch rejected, no outputs change).
- DATA: cnt increments each cycle. When cnt = CLKS_PER_BIT-1:
  - shift rxd_i in LSB-first (shift right, new bit enters at MSB of the DATA_BITS shift register); cnt ← 0.
  - If bit index = DATA_BITS-1 → STOP; otherwise bit index increments.
- STOP: when cnt = CLKS_PER_BIT-1:
  - rxd_i = 1 → deliver and go to IDLE.
  - rxd_i = 0 → frame_err_o pulses, the byte is discarded, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxd_i = 1, then go to IDLE. A held-low line (break) therefore never produces repeated frames.
- Deliver behaviour:
  - valid_o = 0, or valid_o = 1 with ready_i = 1 in the same cycle: data_o ← shift register, valid_o ← 1.
  - Otherwise: overrun_o pulses, data_o and valid_o are unchanged, and the new byte is dropped.
- Handshake: a transfer occurs on a rising edge where valid_o & ready_i. valid_o clears on the next cycle unless a deliver happens on the same edge.
- ready_i is ignored while valid_o = 0.
- A framing error leaves valid_o and data_o untouched.

## Timing
- Reset (async assert, synchronous release effect): state IDLE, cnt 0, bit index 0, shift register 0. Outputs: data_o 0, valid_o 0, frame_err_o 0, overrun_o 0, busy_o 0.
- Reset asserted mid-frame aborts the frame immediately. No partial byte and no error pulse are produced.
- Let edge E be the first rising edge at which IDLE sees rxd_i = 0.
  - Start bit is sampled at E+HALF.
  - Data bit k (0-based) is sampled at E+HALF+(k+1)·CLKS_PER_BIT.
  - Stop bit is sampled at E+HALF+(DATA_BITS+1)·CLKS_PER_BIT.
  - valid_o, frame_err_o and overrun_o change on the stop-sample edge.
- busy_o rises at E and falls on the edge that enters IDLE.
- Back-to-back frames: the next start bit can be detected on the cycle after the return to IDLE. That is about half a bit before the nominal stop end, which is tolerated.
- Pulse outputs are high for exactly one cycle. frame_err_o and overrun_o are never high together.

## Test plan
- CLKS_PER_BIT = 16 and DATA_BITS = 8 for all scenarios.
- Frame 0xA5 with ready_i = 1 → at E+152, valid_o = 1 for one cycle with data_o = 0xA5; busy_o falls on the same edge.
- Glitch: rxd_i low for 4 cycles, then high → no valid_o and no frame_err_o; busy_o is high from E to E+8 only.
- Frame 0x3C with the stop bit low, then the line held low 40 more cycles → one frame_err_o pulse at E+152, no valid_o, busy_o stays high while the line is low. Next frame 0x01 → data_o = 0x01.
- ready_i = 0, frames 0x11 then 0x22 → valid_o stays 1 with data_o = 0x11; overrun_o pulses at the second stop sample. Then ready_i = 1 for one cycle → valid_o drops on the next cycle.
- ready_i = 0, frame 0x11, then ready_i = 1 exactly on the stop-sample edge of frame 0x22 → valid_o stays 1, data_o = 0x22, overrun_o = 0.
- Reset asserted during data bit 3 → all outputs 0 at once. After release, frame 0x5A is received correctly.
